// File: rtl/csr_file_if.sv
// CSR access bus between the datapath (master) and the CSR unit (slave).
// Read data and illegal flag are combinational from the address and strobe.
interface csr_file_if;
    logic [11:0] csr_address;
    logic [1:0]  csr_op;
    logic        csr_write_enable;
    logic [31:0] csr_in;
    logic [31:0] csr_out;
    logic        illegal_csr;

    modport master (
        output csr_address, csr_op, csr_write_enable, csr_in,
        input  csr_out, illegal_csr
    );

    modport slave (
        input  csr_address, csr_op, csr_write_enable, csr_in,
        output csr_out, illegal_csr
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR unit: trap state, trap vector, 64-bit counters, interrupt decision.
// Reads are combinational (read-old); updates land on the clock edge; no backpressure.
module csr_file #(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    csr_file_if.slave   bus,
    input  logic        handle_trap,
    input  logic        trap_is_interrupt,
    input  logic [4:0]  trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_value,
    input  logic        exit_trap,
    output logic [31:0] csr_trap_pc,
    output logic [31:0] csr_ret_pc,
    input  logic        instruction_retired,
    input  logic        external_interrupt,
    input  logic        timer_interrupt,
    output logic        interrupt_pending
);
    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic        mie_meie;
    logic        mie_mtie;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic [31:0] rdata;
    logic        mapped;
    logic [31:0] wdata;
    logic        illegal;
    logic        wr;

    always_comb begin
        rdata  = '0;
        mapped = 1'b1;
        case (bus.csr_address)
            A_MSTATUS:   rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
            A_MISA:      rdata = 32'h4000_0100;
            A_MIE:       rdata = {20'b0, mie_meie, 3'b0, mie_mtie, 7'b0};
            A_MTVEC:     rdata = mtvec;
            A_MSCRATCH:  rdata = mscratch;
            A_MEPC:      rdata = mepc;
            A_MCAUSE:    rdata = mcause;
            A_MTVAL:     rdata = mtval;
            A_MIP:       rdata = {20'b0, external_interrupt, 3'b0, timer_interrupt, 7'b0};
            A_MCYCLE,    A_CYCLE:    rdata = mcycle[31:0];
            A_MCYCLEH,   A_CYCLEH:   rdata = mcycle[63:32];
            A_MINSTRET,  A_INSTRET:  rdata = minstret[31:0];
            A_MINSTRETH, A_INSTRETH: rdata = minstret[63:32];
            A_MHARTID:   rdata = HART_ID;
            default:     mapped = 1'b0;
        endcase
    end

    always_comb begin
        case (bus.csr_op)
            OP_RW:   wdata = bus.csr_in;
            OP_RS:   wdata = rdata | bus.csr_in;
            OP_RC:   wdata = rdata & ~bus.csr_in;
            default: wdata = rdata;
        endcase
    end

    // Read-only space only objects when the access could actually modify something.
    assign illegal = bus.csr_write_enable &
                     (~mapped | ((bus.csr_address[11:10] == 2'b11) &
                                 ((bus.csr_op == OP_RW) | (bus.csr_in != 32'd0))));

    // Trap entry drops the write entirely; mret only shadows writes to mstatus.
    assign wr = bus.csr_write_enable & (bus.csr_op != 2'b00) & ~illegal & ~handle_trap &
                ~(exit_trap & (bus.csr_address == A_MSTATUS));

    assign bus.csr_out     = rdata;
    assign bus.illegal_csr = illegal;

    logic        wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi;
    logic [32:0] cyc_lo_inc, ins_lo_inc;
    logic [63:0] cyc_next, ins_next;

    assign wr_cyc_lo = wr & (bus.csr_address == A_MCYCLE);
    assign wr_cyc_hi = wr & (bus.csr_address == A_MCYCLEH);
    assign wr_ins_lo = wr & (bus.csr_address == A_MINSTRET);
    assign wr_ins_hi = wr & (bus.csr_address == A_MINSTRETH);

    assign cyc_lo_inc = {1'b0, mcycle[31:0]} + 33'd1;
    assign ins_lo_inc = {1'b0, minstret[31:0]} + {32'd0, instruction_retired};

    // A written low half replaces the increment and suppresses its carry that cycle.
    assign cyc_next[31:0]  = wr_cyc_lo ? wdata : cyc_lo_inc[31:0];
    assign cyc_next[63:32] = wr_cyc_hi ? wdata
                           : mcycle[63:32] + {31'd0, cyc_lo_inc[32] & ~wr_cyc_lo};
    assign ins_next[31:0]  = wr_ins_lo ? wdata : ins_lo_inc[31:0];
    assign ins_next[63:32] = wr_ins_hi ? wdata
                           : minstret[63:32] + {31'd0, ins_lo_inc[32] & ~wr_ins_lo};

    always_ff @(posedge clk) begin
        if (reset) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_meie     <= 1'b0;
            mie_mtie     <= 1'b0;
            mtvec        <= TRAP_VECTOR & ~32'h2;
            mscratch     <= '0;
            mepc         <= '0;
            mcause       <= '0;
            mtval        <= '0;
            mcycle       <= '0;
            minstret     <= '0;
        end else begin
            mcycle   <= cyc_next;
            minstret <= ins_next;

            if (handle_trap) begin
                mepc         <= trap_pc & ~32'h3;
                mcause       <= {trap_is_interrupt, 26'b0, trap_cause};
                mtval        <= trap_value;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (exit_trap) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end

            if (wr) begin
                case (bus.csr_address)
                    A_MSTATUS: begin
                        mstatus_mie  <= wdata[3];
                        mstatus_mpie <= wdata[7];
                    end
                    A_MIE: begin
                        mie_mtie <= wdata[7];
                        mie_meie <= wdata[11];
                    end
                    A_MTVEC:    mtvec    <= wdata & ~32'h2;
                    A_MSCRATCH: mscratch <= wdata;
                    A_MEPC:     mepc     <= wdata & ~32'h3;
                    A_MCAUSE:   mcause   <= wdata;
                    A_MTVAL:    mtval    <= wdata;
                    default: ;
                endcase
            end
        end
    end

    logic [31:0] vec_base;
    assign vec_base    = {mtvec[31:2], 2'b00};
    assign csr_trap_pc = (mtvec[0] & trap_is_interrupt)
                       ? vec_base + {25'd0, trap_cause, 2'b00}
                       : vec_base;
    assign csr_ret_pc  = mepc;

    assign interrupt_pending = mstatus_mie &
                               ((mie_meie & external_interrupt) | (mie_mtie & timer_interrupt));
endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: vector table for single-cycle accesses plus
// hand sequences for trap entry/exit, counters and reset override.
module tb_csr_file;
    logic        clk = 1'b0;
    logic        reset;
    logic        handle_trap, trap_is_interrupt, exit_trap;
    logic [4:0]  trap_cause;
    logic [31:0] trap_pc, trap_value;
    logic [31:0] csr_trap_pc, csr_ret_pc;
    logic        instruction_retired, external_interrupt, timer_interrupt;
    logic        interrupt_pending;

    csr_file_if bus_if();

    csr_file #(.HART_ID(32'd0), .TRAP_VECTOR(32'h0000_0102)) dut (
        .clk                 (clk),
        .reset               (reset),
        .bus                 (bus_if.slave),
        .handle_trap         (handle_trap),
        .trap_is_interrupt   (trap_is_interrupt),
        .trap_cause          (trap_cause),
        .trap_pc             (trap_pc),
        .trap_value          (trap_value),
        .exit_trap           (exit_trap),
        .csr_trap_pc         (csr_trap_pc),
        .csr_ret_pc          (csr_ret_pc),
        .instruction_retired (instruction_retired),
        .external_interrupt  (external_interrupt),
        .timer_interrupt     (timer_interrupt),
        .interrupt_pending   (interrupt_pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdat;
        logic [31:0] exp_out;
        logic        chk_out;
        logic        exp_ill;
    } vec_t;

    vec_t tbl[40];
    int   n_vec = 0;

    task automatic add(input logic we, input logic [1:0] op, input logic [11:0] a,
                       input logic [31:0] d, input logic [31:0] e, input logic c, input logic il);
        tbl[n_vec].we      = we;
        tbl[n_vec].op      = op;
        tbl[n_vec].addr    = a;
        tbl[n_vec].wdat    = d;
        tbl[n_vec].exp_out = e;
        tbl[n_vec].chk_out = c;
        tbl[n_vec].exp_ill = il;
        n_vec++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic drv(input logic we, input logic [1:0] op, input logic [11:0] a,
                       input logic [31:0] d);
        bus_if.csr_write_enable = we;
        bus_if.csr_op           = op;
        bus_if.csr_address      = a;
        bus_if.csr_in           = d;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus_if.csr_write_enable = 1'b0;
        bus_if.csr_op           = 2'b00;
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [31:0] e);
        drv(1'b0, 2'b00, a, 32'd0);
        chk(name, bus_if.csr_out, e);
        step();
    endtask

    initial begin
        reset = 1'b1;
        handle_trap = 0; trap_is_interrupt = 0; exit_trap = 0;
        trap_cause = '0; trap_pc = '0; trap_value = '0;
        instruction_retired = 0; external_interrupt = 0; timer_interrupt = 0;
        drv(1'b0, 2'b00, 12'h000, 32'd0);

        add(0, 2'd0, 12'h300, 32'h0,        32'h0000_1800, 1, 0);
        add(0, 2'd0, 12'h301, 32'h0,        32'h4000_0100, 1, 0);
        add(0, 2'd0, 12'hF14, 32'h0,        32'h0,         1, 0);
        add(0, 2'd0, 12'h305, 32'h0,        32'h0000_0100, 1, 0);
        add(1, 2'd1, 12'h340, 32'hA5A5A5A5, 32'h0,         1, 0);
        add(1, 2'd2, 12'h340, 32'h0000FFFF, 32'hA5A5A5A5,  1, 0);
        add(1, 2'd3, 12'h340, 32'hA5000000, 32'hA5A5FFFF,  1, 0);
        add(0, 2'd0, 12'h340, 32'h0,        32'h00A5FFFF,  1, 0);
        add(1, 2'd1, 12'h305, 32'h00001003, 32'h0000_0100, 1, 0);
        add(0, 2'd0, 12'h305, 32'h0,        32'h0000_1001, 1, 0);
        add(1, 2'd1, 12'h341, 32'h12345677, 32'h0,         1, 0);
        add(0, 2'd0, 12'h341, 32'h0,        32'h12345674,  1, 0);
        add(1, 2'd1, 12'h301, 32'hFFFFFFFF, 32'h4000_0100, 1, 0);
        add(0, 2'd0, 12'h301, 32'h0,        32'h4000_0100, 1, 0);
        add(1, 2'd1, 12'hF14, 32'h5,        32'h0,         1, 1);
        add(1, 2'd2, 12'hF14, 32'h0,        32'h0,         1, 0);
        add(1, 2'd3, 12'hF14, 32'h1,        32'h0,         1, 1);
        add(0, 2'd0, 12'h7C0, 32'h0,        32'h0,         0, 0);
        add(1, 2'd1, 12'h7C0, 32'h0,        32'h0,         0, 1);
        add(1, 2'd1, 12'h304, 32'hFFFFFFFF, 32'h0,         1, 0);
        add(0, 2'd0, 12'h304, 32'h0,        32'h0000_0880, 1, 0);
        add(1, 2'd1, 12'h300, 32'hFFFFFFFF, 32'h0000_1800, 1, 0);
        add(0, 2'd0, 12'h300, 32'h0,        32'h0000_1888, 1, 0);
        add(1, 2'd3, 12'h300, 32'h00000088, 32'h0000_1888, 1, 0);
        add(0, 2'd0, 12'h300, 32'h0,        32'h0000_1800, 1, 0);
        add(1, 2'd1, 12'h342, 32'hDEADBEEF, 32'h0,         1, 0);
        add(0, 2'd0, 12'h342, 32'h0,        32'hDEADBEEF,  1, 0);
        add(1, 2'd1, 12'h344, 32'hFFFFFFFF, 32'h0,         1, 0);
        add(0, 2'd0, 12'h344, 32'h0,        32'h0,         1, 0);
        add(1, 2'd1, 12'h343, 32'h00000012, 32'h0,         1, 0);
        add(0, 2'd0, 12'h343, 32'h0,        32'h0000_0012, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // First cycle after reset: counters still zero.
        rd("rst_mcycle", 12'hB00, 32'd0);
        rd("rst_minstret", 12'hB02, 32'd0);
        chk("rst_ret_pc", csr_ret_pc, 32'd0);
        chkb("rst_pending", interrupt_pending, 1'b0);

        for (int i = 0; i < n_vec; i++) begin
            drv(tbl[i].we, tbl[i].op, tbl[i].addr, tbl[i].wdat);
            if (tbl[i].chk_out)
                chk($sformatf("vec%0d_out", i), bus_if.csr_out, tbl[i].exp_out);
            chkb($sformatf("vec%0d_ill", i), bus_if.illegal_csr, tbl[i].exp_ill);
            step();
        end

        // Interrupt enable, trap entry with a coincident (dropped) mtval write.
        drv(1, 2'd2, 12'h300, 32'h8);
        step();
        chkb("pend_no_irq", interrupt_pending, 1'b0);
        external_interrupt = 1'b1;
        drv(0, 2'd0, 12'h344, 32'h0);
        chk("mip_meip", bus_if.csr_out, 32'h0000_0800);
        chkb("pend_ext", interrupt_pending, 1'b1);
        trap_cause = 5'd11; trap_is_interrupt = 1'b0; #1;
        chk("trap_pc_exc", csr_trap_pc, 32'h0000_1000);
        trap_is_interrupt = 1'b1; #1;
        chk("trap_pc_vec", csr_trap_pc, 32'h0000_102C);
        handle_trap = 1'b1; trap_pc = 32'h104; trap_value = 32'h77;
        drv(1, 2'd1, 12'h343, 32'h55);
        step();
        handle_trap = 1'b0;
        rd("trap_mcause", 12'h342, 32'h8000_000B);
        chkb("pend_after_trap", interrupt_pending, 1'b0);
        rd("trap_mepc", 12'h341, 32'h0000_0104);
        rd("trap_mtval", 12'h343, 32'h0000_0077);
        rd("trap_mstatus", 12'h300, 32'h0000_1880);

        // mret with a coincident mstatus write (dropped), then with an mscratch write.
        exit_trap = 1'b1;
        drv(1, 2'd1, 12'h300, 32'h0);
        step();
        exit_trap = 1'b0;
        drv(0, 2'd0, 12'h300, 32'h0);
        chk("mret_mstatus", bus_if.csr_out, 32'h0000_1888);
        chk("mret_ret_pc", csr_ret_pc, 32'h0000_0104);
        chkb("pend_after_mret", interrupt_pending, 1'b1);
        step();
        exit_trap = 1'b1;
        drv(1, 2'd1, 12'h340, 32'h11);
        step();
        exit_trap = 1'b0;
        rd("mret_mscratch", 12'h340, 32'h0000_0011);
        rd("mret2_mstatus", 12'h300, 32'h0000_1888);
        external_interrupt = 1'b0; #1;
        chkb("pend_ext_low", interrupt_pending, 1'b0);

        timer_interrupt = 1'b1; #1;
        chkb("pend_timer", interrupt_pending, 1'b1);
        drv(1, 2'd3, 12'h304, 32'h80);
        step();
        chkb("pend_mtie_off", interrupt_pending, 1'b0);
        timer_interrupt = 1'b0;

        drv(1, 2'd1, 12'h305, 32'h2000);
        step();
        trap_cause = 5'd3; trap_is_interrupt = 1'b1; #1;
        chk("trap_pc_direct", csr_trap_pc, 32'h0000_2000);

        // Cycle counter wrap and carry.
        rd("mcycleh_base", 12'hB80, 32'd0);
        drv(1, 2'd1, 12'hB00, 32'hFFFF_FFFF);
        step();
        rd("mcycle_written", 12'hB00, 32'hFFFF_FFFF);
        rd("mcycleh_carry", 12'hB80, 32'd1);
        rd("cycle_shadow", 12'hC00, 32'd1);
        rd("cycleh_shadow", 12'hC80, 32'd1);
        drv(1, 2'd1, 12'hB00, 32'hFFFF_FFFF);
        step();
        drv(1, 2'd1, 12'hB80, 32'h20);
        step();
        rd("mcycleh_wr_nocarry", 12'hB80, 32'h20);
        rd("mcycle_after_wrap", 12'hB00, 32'd1);
        drv(1, 2'd1, 12'hC00, 32'h0);
        chkb("cycle_rw_ill", bus_if.illegal_csr, 1'b1);
        chk("cycle_rw_out", bus_if.csr_out, 32'd2);
        step();
        rd("cycle_unchanged", 12'hC00, 32'd3);
        drv(1, 2'd2, 12'hC00, 32'h0);
        chkb("cycle_rs0_legal", bus_if.illegal_csr, 1'b0);
        step();

        // Retired-instruction counter.
        instruction_retired = 1'b1;
        drv(1, 2'd1, 12'hB02, 32'd5);
        step();
        rd("minstret_wr", 12'hB02, 32'd5);
        instruction_retired = 1'b0;
        rd("minstret_inc", 12'hB02, 32'd6);
        rd("minstret_hold", 12'hB02, 32'd6);
        instruction_retired = 1'b1;
        drv(1, 2'd1, 12'hB02, 32'hFFFF_FFFF);
        step();
        rd("minstreth_pre", 12'hB82, 32'd0);
        rd("minstreth_carry", 12'hB82, 32'd1);
        instruction_retired = 1'b0;

        // Reset wins over a simultaneous trap strobe.
        reset = 1'b1; handle_trap = 1'b1; trap_pc = 32'h200;
        step();
        reset = 1'b0; handle_trap = 1'b0;
        rd("rst2_mepc", 12'h341, 32'd0);
        rd("rst2_mstatus", 12'h300, 32'h0000_1800);
        rd("rst2_mtvec", 12'h305, 32'h0000_0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
